// File: rtl/micro_pkg.sv
// Shared encodings and microword field layout for the microprogram sequencer.
package micro_pkg;

  // Microword field placement, LSB upward: cond sel, seq op, addr, ctrl.
  localparam int unsigned COND_LSB = 0;
  localparam int unsigned COND_W   = 2;
  localparam int unsigned SEQ_LSB  = COND_LSB + COND_W;
  localparam int unsigned SEQ_W    = 3;
  localparam int unsigned ADDR_LSB = SEQ_LSB + SEQ_W;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_BRANCH   = 3'd2,
    SEQ_DISPATCH = 3'd3,
    SEQ_CALL     = 3'd4,
    SEQ_RET      = 3'd5,
    SEQ_HALT     = 3'd6,
    SEQ_RSVD     = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_Z      = 2'd1,
    COND_C      = 2'd2,
    COND_N      = 2'd3
  } cond_sel_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fsm_state_e;

  // Bit position of the ctrl field for a given micro-address width.
  function automatic int unsigned ctrl_lsb(input int unsigned uaddr_w);
    return ADDR_LSB + uaddr_w;
  endfunction

  // Total microword width.
  function automatic int unsigned uword_w(input int unsigned ctrl_w, input int unsigned uaddr_w);
    return ctrl_w + uaddr_w + ADDR_LSB;
  endfunction

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next-uPC selection from the sequencing field of the current microword.
module micro_next_addr
  import micro_pkg::*;
#(
  parameter int unsigned UADDR_W  = 8,
  parameter int unsigned OPCODE_W = 4
) (
  input  seq_op_e              i_seq_op,
  input  cond_sel_e            i_cond_sel,
  input  logic                 i_flag_z,
  input  logic                 i_flag_c,
  input  logic                 i_flag_n,
  input  logic [OPCODE_W-1:0]  i_opcode,
  input  logic [UADDR_W-1:0]   i_addr,
  input  logic [UADDR_W-1:0]   i_upc,
  input  logic [UADDR_W-1:0]   i_ret,
  output logic [UADDR_W-1:0]   o_next_upc_c,
  output logic                 o_push_ret_c
);

  if (OPCODE_W > UADDR_W) begin : g_bad_opcode_w
    $error("OPCODE_W must not exceed UADDR_W");
  end

  logic                w_cond;
  logic [UADDR_W-1:0]  w_upc_inc;

  // Increment wraps naturally at the address width.
  assign w_upc_inc = i_upc + UADDR_W'(1);

  // Branch condition select.
  always_comb begin
    w_cond = 1'b1;
    case (i_cond_sel)
      COND_ALWAYS: w_cond = 1'b1;
      COND_Z:      w_cond = i_flag_z;
      COND_C:      w_cond = i_flag_c;
      COND_N:      w_cond = i_flag_n;
      default:     w_cond = 1'b1;
    endcase
  end

  // Next-address mux; HALT keeps the current uPC, reserved falls through as NEXT.
  always_comb begin
    o_next_upc_c = w_upc_inc;
    o_push_ret_c = 1'b0;
    case (i_seq_op)
      SEQ_JUMP:     o_next_upc_c = i_addr;
      SEQ_BRANCH:   o_next_upc_c = w_cond ? i_addr : w_upc_inc;
      SEQ_DISPATCH: o_next_upc_c = UADDR_W'(i_opcode) << (UADDR_W - OPCODE_W);
      SEQ_CALL: begin
        o_next_upc_c = i_addr;
        o_push_ret_c = 1'b1;
      end
      SEQ_RET:      o_next_upc_c = i_ret;
      SEQ_HALT:     o_next_upc_c = i_upc;
      default:      o_next_upc_c = w_upc_inc;
    endcase
  end

endmodule

// File: rtl/micro_seq.sv
// Microprogram sequencer: owns uPC, one-deep return register and RUN/HALTED FSM.
module micro_seq
  import micro_pkg::*;
#(
  parameter int unsigned         UADDR_W   = 8,
  parameter int unsigned         CTRL_W    = 24,
  parameter int unsigned         OPCODE_W  = 4,
  parameter logic [UADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic                             i_clk,
  input  logic                             i_res,
  input  logic                             i_stall,
  input  logic                             i_resume,
  input  logic [OPCODE_W-1:0]              i_opcode,
  input  logic                             i_flag_z,
  input  logic                             i_flag_c,
  input  logic                             i_flag_n,
  output logic [UADDR_W-1:0]               o_uaddr,
  input  logic [CTRL_W+UADDR_W+ADDR_LSB-1:0] i_urom_data,
  output logic [CTRL_W-1:0]                o_ctrl,
  output logic                             o_halted
);

  localparam int unsigned CTRL_LSB = ctrl_lsb(UADDR_W);

  fsm_state_e          r_state;
  fsm_state_e          w_state_nxt;
  logic [UADDR_W-1:0]  r_upc;
  logic [UADDR_W-1:0]  w_upc_nxt;
  logic [UADDR_W-1:0]  r_ret;
  logic [UADDR_W-1:0]  w_ret_nxt;
  logic [UADDR_W-1:0]  w_upc_inc;
  logic [UADDR_W-1:0]  w_seq_upc;
  logic                w_push_ret;
  seq_op_e             w_seq_op;
  cond_sel_e           w_cond_sel;
  logic [UADDR_W-1:0]  w_addr;
  logic [CTRL_W-1:0]   w_ctrl_field;

  assign w_seq_op     = seq_op_e'(i_urom_data[SEQ_LSB +: SEQ_W]);
  assign w_cond_sel   = cond_sel_e'(i_urom_data[COND_LSB +: COND_W]);
  assign w_addr       = i_urom_data[ADDR_LSB +: UADDR_W];
  assign w_ctrl_field = i_urom_data[CTRL_LSB +: CTRL_W];
  assign w_upc_inc    = r_upc + UADDR_W'(1);

  micro_next_addr #(
    .UADDR_W  (UADDR_W),
    .OPCODE_W (OPCODE_W)
  ) u_next_addr (
    .i_seq_op     (w_seq_op),
    .i_cond_sel   (w_cond_sel),
    .i_flag_z     (i_flag_z),
    .i_flag_c     (i_flag_c),
    .i_flag_n     (i_flag_n),
    .i_opcode     (i_opcode),
    .i_addr       (w_addr),
    .i_upc        (r_upc),
    .i_ret        (r_ret),
    .o_next_upc_c (w_seq_upc),
    .o_push_ret_c (w_push_ret)
  );

  // State, uPC and return register.
  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_state <= ST_RUN;
      r_upc   <= RESET_VEC;
      r_ret   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_upc   <= w_upc_nxt;
      r_ret   <= w_ret_nxt;
    end
  end

  // Next-state logic; stall freezes everything, including a pending resume.
  always_comb begin
    w_state_nxt = r_state;
    w_upc_nxt   = r_upc;
    w_ret_nxt   = r_ret;
    if (!i_stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_seq_op == SEQ_HALT) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_upc_nxt = w_seq_upc;
            if (w_push_ret) begin
              w_ret_nxt = w_upc_inc;
            end
          end
        end
        ST_HALTED: begin
          if (i_resume) begin
            w_state_nxt = ST_RUN;
            w_upc_nxt   = w_upc_inc;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Control word passes straight through from the ROM when running, gated by reset.
  assign o_ctrl   = (i_res && (r_state == ST_RUN) && !i_stall) ? w_ctrl_field : '0;
  assign o_uaddr  = r_upc;
  assign o_halted = (r_state == ST_HALTED);

endmodule

// File: tb/tb_micro_seq.sv
// Self-checking bench for micro_seq: directed scenarios plus randomized run against a behavioural model.
module tb_micro_seq;

  localparam int unsigned UADDR_W  = 8;
  localparam int unsigned CTRL_W   = 24;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned UW       = CTRL_W + UADDR_W + 5;

  logic               clk    = 1'b0;
  logic               res    = 1'b1;
  logic               stall  = 1'b0;
  logic               resume = 1'b0;
  logic               fz     = 1'b0;
  logic               fc     = 1'b0;
  logic               fn     = 1'b0;
  logic [3:0]         opcode = 4'h0;
  logic [7:0]         uaddr;
  logic [UW-1:0]      urom;
  logic [CTRL_W-1:0]  ctrl;
  logic               halted;

  logic [UW-1:0]      rom [256];

  int checks  = 0;
  int passes  = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  // External combinational microcode ROM.
  always @* urom = rom[uaddr];

  micro_seq #(
    .UADDR_W   (UADDR_W),
    .CTRL_W    (CTRL_W),
    .OPCODE_W  (OPCODE_W),
    .RESET_VEC (8'h00)
  ) dut (
    .i_clk       (clk),
    .i_res       (res),
    .i_stall     (stall),
    .i_resume    (resume),
    .i_opcode    (opcode),
    .i_flag_z    (fz),
    .i_flag_c    (fc),
    .i_flag_n    (fn),
    .o_uaddr     (uaddr),
    .i_urom_data (urom),
    .o_ctrl      (ctrl),
    .o_halted    (halted)
  );

  function automatic logic [UW-1:0] mk(input logic [23:0] c, input logic [7:0] a,
                                       input logic [2:0] op, input logic [1:0] cs);
    return {c, a, op, cs};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: uPC as integer address, arithmetic modulo 256.
  int m_upc    = 0;
  int m_ret    = 0;
  bit m_halted = 1'b0;

  always @(posedge clk or negedge res) begin : model
    logic [UW-1:0] w;
    int            a;
    bit            cnd;
    if (!res) begin
      m_upc    = 0;
      m_ret    = 0;
      m_halted = 1'b0;
    end else if (!stall) begin
      w = rom[m_upc];
      a = int'(w[12:5]);
      if (m_halted) begin
        if (resume) begin
          m_halted = 1'b0;
          m_upc    = (m_upc + 1) % 256;
        end
      end else begin
        case (w[4:2])
          3'd1: m_upc = a;
          3'd2: begin
            case (w[1:0])
              2'd0:    cnd = 1'b1;
              2'd1:    cnd = fz;
              2'd2:    cnd = fc;
              default: cnd = fn;
            endcase
            m_upc = cnd ? a : (m_upc + 1) % 256;
          end
          3'd3: m_upc = int'(opcode) * 16;
          3'd4: begin
            m_ret = (m_upc + 1) % 256;
            m_upc = a;
          end
          3'd5: m_upc = m_ret;
          3'd6: m_halted = 1'b1;
          default: m_upc = (m_upc + 1) % 256;
        endcase
      end
    end
  end

  function automatic logic [CTRL_W-1:0] exp_ctrl();
    logic [UW-1:0] w;
    w = rom[m_upc];
    return (res && !m_halted && !stall) ? w[UW-1:13] : '0;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("uaddr", 64'(uaddr), 64'(m_upc));
      chk("halted", 64'(halted), 64'(m_halted));
      chk("ctrl", 64'(ctrl), 64'(exp_ctrl()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset (checking async clear) then jump from RESET_VEC to the given address.
  task automatic start_at(input logic [7:0] a);
    step();
    rom[0] = mk(24'h0F0F0F, a, 3'd1, 2'd0);
    res = 1'b0;
    #1;
    chk("rst_uaddr", 64'(uaddr), 64'h00);
    chk("rst_ctrl", 64'(ctrl), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    res = 1'b1;
    step();
    chk("jump_uaddr", 64'(uaddr), 64'(a));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = UW'({$urandom(), $urandom()});

    // Reset and sequential fetch.
    rom[0] = mk(24'hA5A5A5, 8'h00, 3'd0, 2'd0);
    rom[1] = mk(24'h123456, 8'h77, 3'd0, 2'd3);
    rom[2] = mk(24'h00BEEF, 8'h11, 3'd0, 2'd1);
    #1 res = 1'b0;
    #2;
    run_cmp = 1'b1;
    chk("hold_uaddr", 64'(uaddr), 64'h00);
    chk("hold_ctrl", 64'(ctrl), 64'h0);
    chk("hold_halted", 64'(halted), 64'h0);
    @(posedge clk);
    #1 res = 1'b1;
    #1;
    chk("seq0_uaddr", 64'(uaddr), 64'h00);
    chk("seq0_ctrl", 64'(ctrl), 64'hA5A5A5);
    step();
    chk("seq1_uaddr", 64'(uaddr), 64'h01);
    chk("seq1_ctrl", 64'(ctrl), 64'h123456);
    step();
    chk("seq2_uaddr", 64'(uaddr), 64'h02);
    chk("seq2_ctrl", 64'(ctrl), 64'h00BEEF);

    // Dispatch.
    rom[8'h50] = mk(24'h000001, 8'h00, 3'd3, 2'd0);
    opcode = 4'hA;
    start_at(8'h50);
    step();
    chk("dispatch_A", 64'(uaddr), 64'hA0);
    opcode = 4'h3;
    start_at(8'h50);
    step();
    chk("dispatch_3", 64'(uaddr), 64'h30);
    opcode = 4'h0;

    // Conditional branch on Z, then unconditional.
    rom[8'h12] = mk(24'h000002, 8'h40, 3'd2, 2'd1);
    fz = 1'b1;
    start_at(8'h12);
    step();
    chk("branch_z1", 64'(uaddr), 64'h40);
    fz = 1'b0;
    start_at(8'h12);
    step();
    chk("branch_z0", 64'(uaddr), 64'h13);
    rom[8'h12] = mk(24'h000003, 8'h40, 3'd2, 2'd0);
    start_at(8'h12);
    step();
    chk("branch_always", 64'(uaddr), 64'h40);

    // Call / return.
    rom[8'h10] = mk(24'h000004, 8'h80, 3'd4, 2'd0);
    rom[8'h80] = mk(24'h000005, 8'h00, 3'd5, 2'd0);
    start_at(8'h10);
    step();
    chk("call_uaddr", 64'(uaddr), 64'h80);
    step();
    chk("ret_uaddr", 64'(uaddr), 64'h11);

    // Stall.
    rom[8'h05] = mk(24'h5A5A5A, 8'h00, 3'd0, 2'd0);
    start_at(8'h05);
    stall = 1'b1;
    #1;
    chk("stall_ctrl", 64'(ctrl), 64'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_uaddr", 64'(uaddr), 64'h05);
    end
    stall = 1'b0;
    #1;
    chk("unstall_ctrl", 64'(ctrl), 64'h5A5A5A);
    step();
    chk("unstall_uaddr", 64'(uaddr), 64'h06);

    // Halt and resume.
    rom[8'h20] = mk(24'hC0FFEE, 8'h00, 3'd6, 2'd0);
    start_at(8'h20);
    #1;
    chk("halt_word_ctrl", 64'(ctrl), 64'hC0FFEE);
    chk("halt_word_halted", 64'(halted), 64'h0);
    step();
    chk("halted_flag", 64'(halted), 64'h1);
    chk("halted_uaddr", 64'(uaddr), 64'h20);
    chk("halted_ctrl", 64'(ctrl), 64'h0);
    resume = 1'b1;
    stall  = 1'b1;
    step();
    chk("resume_stalled", 64'(halted), 64'h1);
    chk("resume_stalled_uaddr", 64'(uaddr), 64'h20);
    stall = 1'b0;
    step();
    chk("resume_halted", 64'(halted), 64'h0);
    chk("resume_uaddr", 64'(uaddr), 64'h21);
    resume = 1'b0;

    // Wrap-around of increment and of the saved return address.
    rom[8'hFF] = mk(24'h000006, 8'h00, 3'd0, 2'd0);
    start_at(8'hFF);
    step();
    chk("wrap_next", 64'(uaddr), 64'h00);
    rom[8'hFF] = mk(24'h000007, 8'h60, 3'd4, 2'd0);
    rom[8'h60] = mk(24'h000008, 8'h00, 3'd5, 2'd0);
    start_at(8'hFF);
    step();
    chk("wrap_call", 64'(uaddr), 64'h60);
    step();
    chk("wrap_ret", 64'(uaddr), 64'h00);

    // Asynchronous reset mid-cycle.
    rom[8'h37] = mk(24'h373737, 8'h00, 3'd0, 2'd0);
    start_at(8'h37);
    #1;
    chk("pre_async_ctrl", 64'(ctrl), 64'h373737);
    #2 res = 1'b0;
    #1;
    chk("async_uaddr", 64'(uaddr), 64'h00);
    chk("async_ctrl", 64'(ctrl), 64'h0);
    #1 res = 1'b1;

    // Randomized run against the model.
    for (int i = 0; i < 256; i++) rom[i] = UW'({$urandom(), $urandom()});
    for (int n = 0; n < 3000; n++) begin
      step();
      stall  = ($urandom_range(0, 9) == 0);
      resume = ($urandom_range(0, 2) == 0);
      fz     = 1'($urandom());
      fc     = 1'($urandom());
      fn     = 1'($urandom());
      opcode = 4'($urandom());
      res    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) rom[$urandom_range(0, 255)] = UW'({$urandom(), $urandom()});
    end
    res = 1'b1;
    step();
    run_cmp = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
